// File: rtl/fp_add_norm_sequencer.sv
// Normalization sequencer between the FP adder mantissa add and pack/round stages.
// Define FP_NORM_FAST_EN to replace the bit-serial left shift with a one-cycle leading-one shift.
module fp_add_norm_sequencer #(
  parameter int MENT_WIDTH = 23,
  parameter int EXP_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [EXP_WIDTH-1:0]  in_exponent,
  input  logic [MENT_WIDTH+1:0] in_sum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sign,
  output logic [EXP_WIDTH-1:0]  out_exponent,
  output logic [MENT_WIDTH-1:0] out_mentissa,
  output logic                  out_zero,
  output logic                  out_overflow,
  output logic                  out_underflow
);

  // state   | meaning
  // S_IDLE  | waiting for a stage-3 result (in_ready high)
  // S_CHECK | classify captured sum: zero / carry / normalized / denormal / needs shift
  // S_SHIFT | left-normalize, decrementing the exponent
  // S_DONE  | result presented, held until stage 5 accepts
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_SHIFT, S_DONE} state_t;

  localparam int SW = MENT_WIDTH + 2;
  localparam logic [EXP_WIDTH-1:0] EXP_MAX = '1;
  localparam logic [EXP_WIDTH-1:0] EXP_ONE = EXP_WIDTH'(1);

  state_t               r_state, w_state_nxt;
  logic [SW-1:0]        r_sum, w_sum_nxt;
  logic [EXP_WIDTH-1:0] r_exp, w_exp_nxt;
  logic                 r_sign, w_sign_nxt;
  logic                 r_zero, w_zero_nxt;
  logic                 r_ovf, w_ovf_nxt;
  logic                 r_unf, w_unf_nxt;
  logic [SW-1:0]        w_sum_shr;
  logic [EXP_WIDTH-1:0] w_exp_m1;

  assign w_sum_shr = r_sum >> 1;
  assign w_exp_m1  = r_exp - EXP_ONE;

`ifdef FP_NORM_FAST_EN
  localparam int KW = $clog2(MENT_WIDTH + 1);
  logic [KW-1:0]        w_lz;
  logic [EXP_WIDTH-1:0] w_k_ext;
  logic [EXP_WIDTH-1:0] w_shamt;
  logic                 w_unf_fast;
  logic [SW-1:0]        w_sum_fast;

  // Ascending scan so the highest set bit determines the leading-zero count.
  always_comb begin
    w_lz = '0;
    for (int i = 0; i <= MENT_WIDTH; i++) begin
      if (r_sum[i]) w_lz = KW'(MENT_WIDTH - i);
    end
  end

  assign w_k_ext    = EXP_WIDTH'(w_lz);
  assign w_unf_fast = (w_k_ext > w_exp_m1);
  assign w_shamt    = w_unf_fast ? w_exp_m1 : w_k_ext;
  assign w_sum_fast = r_sum << w_shamt;
`else
  logic [SW-1:0] w_sum_shl;
  assign w_sum_shl = r_sum << 1;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sum   <= '0;
      r_exp   <= '0;
      r_sign  <= 1'b0;
      r_zero  <= 1'b0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sum   <= w_sum_nxt;
      r_exp   <= w_exp_nxt;
      r_sign  <= w_sign_nxt;
      r_zero  <= w_zero_nxt;
      r_ovf   <= w_ovf_nxt;
      r_unf   <= w_unf_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sum_nxt   = r_sum;
    w_exp_nxt   = r_exp;
    w_sign_nxt  = r_sign;
    w_zero_nxt  = r_zero;
    w_ovf_nxt   = r_ovf;
    w_unf_nxt   = r_unf;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_sign_nxt  = in_sign;
          w_exp_nxt   = in_exponent;
          w_sum_nxt   = in_sum;
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        w_state_nxt = S_DONE;
        if (r_sum == '0) begin
          w_exp_nxt  = '0;
          w_zero_nxt = 1'b1;
        end else if (r_sum[SW-1]) begin
          // An already-saturated exponent also saturates rather than wrapping.
          if (r_exp >= EXP_MAX - EXP_ONE) begin
            w_exp_nxt = EXP_MAX;
            w_sum_nxt = {w_sum_shr[SW-1:MENT_WIDTH], {MENT_WIDTH{1'b0}}};
            w_ovf_nxt = 1'b1;
          end else begin
            w_exp_nxt = r_exp + EXP_ONE;
            w_sum_nxt = w_sum_shr;
          end
        end else if (r_sum[MENT_WIDTH]) begin
          w_state_nxt = S_DONE;
        end else if (r_exp == '0) begin
          w_unf_nxt = 1'b1;
        end else begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
`ifdef FP_NORM_FAST_EN
        w_sum_nxt   = w_sum_fast;
        w_exp_nxt   = w_unf_fast ? '0 : (r_exp - w_shamt);
        w_unf_nxt   = w_unf_fast;
        w_state_nxt = S_DONE;
`else
        if (r_exp == EXP_ONE && !r_sum[MENT_WIDTH]) begin
          w_exp_nxt   = '0;
          w_unf_nxt   = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_sum_nxt = w_sum_shl;
          w_exp_nxt = w_exp_m1;
          if (w_sum_shl[MENT_WIDTH]) w_state_nxt = S_DONE;
        end
`endif
      end
      S_DONE: begin
        if (out_ready) begin
          w_zero_nxt  = 1'b0;
          w_ovf_nxt   = 1'b0;
          w_unf_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign in_ready      = (r_state == S_IDLE);
  assign out_valid     = (r_state == S_DONE);
  assign out_sign      = r_sign;
  assign out_exponent  = r_exp;
  assign out_mentissa  = r_sum[MENT_WIDTH-1:0];
  assign out_zero      = r_zero;
  assign out_overflow  = r_ovf;
  assign out_underflow = r_unf;

endmodule

// File: tb/tb_fp_add_norm_sequencer.sv
// Self-checking bench for fp_add_norm_sequencer: arithmetic reference model plus directed vectors.
// Honours FP_NORM_FAST_EN for the expected shift latency.
module tb_fp_add_norm_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exponent = '0;
  logic [24:0] in_sum = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sign;
  logic [7:0]  out_exponent;
  logic [22:0] out_mentissa;
  logic        out_zero;
  logic        out_overflow;
  logic        out_underflow;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [7:0]  e;
    logic [22:0] m;
    bit          z;
    bit          o;
    bit          u;
    int          lat;
  } res_t;

  bit          m_active = 1'b0;
  logic        m_s;
  res_t        m_r;

  fp_add_norm_sequencer #(.MENT_WIDTH(23), .EXP_WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exponent(in_exponent), .in_sum(in_sum),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exponent(out_exponent), .out_mentissa(out_mentissa),
    .out_zero(out_zero), .out_overflow(out_overflow), .out_underflow(out_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Value-level reference: latency counts edges from the accept edge through the edge raising out_valid.
  function automatic res_t model(input logic [7:0] e, input logic [24:0] s);
    res_t   r;
    longint v;
    int     ev;
    int     k;
    v = longint'(s);
    ev = int'(e);
    r.e = '0; r.m = '0; r.z = 0; r.o = 0; r.u = 0; r.lat = 2;
    if (v == 0) begin
      r.z = 1;
    end else if (v >= 64'h100_0000) begin
      ev = ev + 1;
      if (ev >= 255) begin
        r.e = 8'hFF; r.o = 1;
      end else begin
        r.e = 8'(ev); r.m = 23'((v / 2) % 64'h80_0000);
      end
    end else if (v >= 64'h80_0000) begin
      r.e = e; r.m = 23'(v % 64'h80_0000);
    end else if (ev == 0) begin
      r.u = 1; r.m = 23'(v);
    end else begin
      k = 0;
      while (v < 64'h80_0000 && ev > 1) begin
        v = v * 2; ev = ev - 1; k = k + 1;
      end
      if (v < 64'h80_0000) begin
        r.u = 1; ev = 0; r.lat = 3 + k;
      end else begin
        r.lat = 2 + k;
      end
`ifdef FP_NORM_FAST_EN
      r.lat = 3;
`endif
      r.e = 8'(ev);
      r.m = 23'(v % 64'h80_0000);
    end
    return r;
  endfunction

  // Every cycle the DUT presents a result, it must match the model and stay stable.
  always @(negedge clk) begin
    if (!rst && m_active && out_valid) begin
      chk("out_sign", out_sign, m_s);
      chk("out_exponent", out_exponent, m_r.e);
      chk("out_mentissa", out_mentissa, m_r.m);
      chk("out_zero", out_zero, m_r.z);
      chk("out_overflow", out_overflow, m_r.o);
      chk("out_underflow", out_underflow, m_r.u);
      chk("in_ready_in_done", in_ready, 1'b0);
    end
  end

  task automatic run_op(input logic sg, input logic [7:0] e, input logic [24:0] s, input int hold);
    int lat;
    @(negedge clk);
    chk("in_ready_idle", in_ready, 1'b1);
    m_r = model(e, s);
    m_s = sg;
    m_active = 1'b1;
    in_valid = 1'b1; in_sign = sg; in_exponent = e; in_sum = s;
    out_ready = (hold == 0);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, m_r.lat);
    if (hold > 0) begin
      in_valid = 1'b1; in_sign = ~sg; in_exponent = 8'h42; in_sum = 25'h155_5555;
      repeat (hold) @(negedge clk);
      chk("held_valid", out_valid, 1'b1);
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    m_active = 1'b0;
    chk("out_valid_after", out_valid, 1'b0);
    chk("in_ready_after", in_ready, 1'b1);
    chk("flags_cleared", {out_zero, out_overflow, out_underflow}, 3'b000);
  endtask

  initial begin
    res_t p;
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    res_t p;
    // Hand-computed pins on the reference model itself.
    p = model(8'h90, 25'h000_0100);
    chk("pin_k15_exp", p.e, 8'h81);
    chk("pin_k15_mant", p.m, 23'h0);
`ifdef FP_NORM_FAST_EN
    chk("pin_k15_lat", p.lat, 3);
`else
    chk("pin_k15_lat", p.lat, 17);
`endif
    p = model(8'h03, 25'h000_0100);
    chk("pin_unf_mant", p.m, 23'h000400);
    chk("pin_unf_flag", {p.e, p.u}, {8'h00, 1'b1});
    p = model(8'h7F, 25'h180_0001);
    chk("pin_carry", {p.e, p.m}, {8'h80, 23'h400000});
    p = model(8'hFE, 25'h180_0001);
    chk("pin_ovf", {p.e, p.m, p.o}, {8'hFF, 23'h0, 1'b1});

    // Reset state
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_outputs", {out_valid, out_sign, out_exponent, out_mentissa, out_zero, out_overflow, out_underflow}, 36'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(1'b0, 8'h80, 25'h0C0_0000, 0);  // normalized
    run_op(1'b1, 8'h7F, 25'h180_0001, 0);  // carry, LSB truncated
    run_op(1'b0, 8'hFE, 25'h180_0001, 0);  // carry into overflow
    run_op(1'b0, 8'h90, 25'h000_0100, 0);  // k=15
    run_op(1'b1, 8'h03, 25'h000_0100, 0);  // underflow mid-shift
    run_op(1'b0, 8'h55, 25'h000_0000, 0);  // exact zero
    run_op(1'b1, 8'h00, 25'h000_0100, 0);  // already denormal
    run_op(1'b0, 8'h01, 25'h000_0100, 0);  // exp=1, immediate underflow
    run_op(1'b0, 8'h10, 25'h040_0000, 0);  // k=1
    run_op(1'b1, 8'h80, 25'h000_0001, 0);  // k=23
    run_op(1'b0, 8'h18, 25'h000_0001, 0);  // k exactly exp-1
    run_op(1'b1, 8'h80, 25'h0C0_0000, 5);  // back-pressure

    // Reset in the middle of a shift sequence.
    @(negedge clk);
    in_valid = 1'b1; in_sign = 1'b1; in_exponent = 8'h90; in_sum = 25'h000_0100; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_outputs", {out_valid, out_sign, out_exponent, out_mentissa, out_zero, out_overflow, out_underflow}, 36'h0);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_no_output", out_valid, 1'b0);
    run_op(1'b0, 8'h90, 25'h000_0100, 0);
    run_op(1'b1, 8'h7F, 25'h180_0001, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
